// File: rtl/ibex_perf_counter_bank.sv
// Machine counter/timer bank: mcycle, minstret and NUM_HPM mhpmcounters, each with
// a sticky overflow flag, plus mhpmevent selectors and mcountinhibit.
module ibex_perf_counter_bank #(
    parameter int NUM_HPM       = 8,
    parameter int COUNTER_WIDTH = 40,
    parameter int NUM_EVENTS    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_access_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [1:0]            csr_op_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic                  instr_ret_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  count_stop_i,
    input  logic                  ovf_irq_en_i,
    output logic [NUM_HPM+2:0]    ovf_o,
    output logic                  ovf_irq_o
);

    localparam int NC = NUM_HPM + 3;
    localparam int W  = COUNTER_WIDTH;
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [NC-1:0] INH_MASK = ~(NC'(2));

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    csr_op_e               op;
    logic [W-1:0]          cnt [NC];
    logic [NUM_EVENTS-1:0] evt [NC];
    logic [NC-1:0]         inhibit;
    logic [NC-1:0]         ovf_q;
    logic [NC-1:0]         inc;
    logic [NC-1:0]         wr_lo;
    logic [NC-1:0]         wr_hi;
    logic [NC-1:0]         wr_evt;
    logic                  wr_inh;
    logic                  wr;
    logic                  in_mc;
    logic                  in_lo;
    logic                  in_hi;
    logic [31:0]           old_val;
    logic [31:0]           new_val;
    logic [63:0]           cnt_ext;

    assign op = csr_op_e'(csr_op_i);

    // Index 1 (the time slot) is never selected, so it reads 0 and drops writes.
    always_comb begin
        in_mc   = (csr_addr_i[11:5] == 7'h19);
        in_lo   = (csr_addr_i[11:5] == 7'h58);
        in_hi   = (csr_addr_i[11:5] == 7'h5C);
        wr      = csr_access_i && (op != CSR_OP_READ);
        wr_inh  = wr && in_mc && (csr_addr_i[4:0] == 5'd0);
        old_val = '0;
        cnt_ext = '0;
        wr_lo   = '0;
        wr_hi   = '0;
        wr_evt  = '0;
        if (in_mc && (csr_addr_i[4:0] == 5'd0)) begin
            old_val = 32'(inhibit);
        end
        for (int k = 0; k < NC; k++) begin
            if (csr_addr_i[4:0] == 5'(k)) begin
                if (k >= 3 && in_mc) begin
                    old_val   = 32'(evt[k]);
                    wr_evt[k] = wr;
                end
                if (k != 1 && (in_lo || in_hi)) begin
                    cnt_ext  = 64'(cnt[k]);
                    old_val  = in_lo ? cnt_ext[31:0] : cnt_ext[63:32];
                    wr_lo[k] = wr && in_lo;
                    wr_hi[k] = wr && in_hi;
                end
            end
        end
    end

    always_comb begin
        new_val = old_val;
        case (op)
            CSR_OP_WRITE: new_val = csr_wdata_i;
            CSR_OP_SET:   new_val = old_val | csr_wdata_i;
            CSR_OP_CLEAR: new_val = old_val & ~csr_wdata_i;
            default:      new_val = old_val;
        endcase
    end

    always_comb begin
        inc = '0;
        for (int k = 0; k < NC; k++) begin
            if (k == 0) begin
                inc[k] = 1'b1;
            end else if (k == 2) begin
                inc[k] = instr_ret_i;
            end else if (k >= 3) begin
                inc[k] = |(event_i & evt[k]);
            end
            inc[k] = inc[k] && !inhibit[k] && !count_stop_i;
        end
    end

    assign csr_hit_o   = in_mc || in_lo || in_hi;
    assign csr_rdata_o = csr_access_i ? old_val : 32'd0;
    assign ovf_o       = ovf_q;
    assign ovf_irq_o   = ovf_irq_en_i && (|ovf_q);

    // A write to either half suppresses the whole counter's increment and its
    // overflow, so a half-write never sees a carry from the other half.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inhibit <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < NC; k++) begin
                cnt[k] <= '0;
                evt[k] <= '0;
            end
        end else begin
            if (wr_inh) begin
                inhibit <= new_val[NC-1:0] & INH_MASK;
            end
            for (int k = 0; k < NC; k++) begin
                if (wr_evt[k]) begin
                    evt[k] <= new_val[NUM_EVENTS-1:0];
                end
                if (wr_lo[k] || wr_hi[k]) begin
                    if (wr_lo[k]) begin
                        cnt[k][31:0] <= new_val;
                    end
                    if (wr_hi[k]) begin
                        cnt[k][W-1:32] <= new_val[W-33:0];
                    end
                    ovf_q[k] <= 1'b0;
                end else if (inc[k]) begin
                    cnt[k] <= cnt[k] + CNT_ONE;
                    if (&cnt[k]) begin
                        ovf_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_perf_counter_bank.sv
// Directed and randomized checks of ibex_perf_counter_bank against a plain-arithmetic
// model of the counters, event selectors, inhibit mask and overflow flags.
module tb_ibex_perf_counter_bank;

    localparam int NH = 8;
    localparam int W  = 40;
    localparam int NE = 16;
    localparam int NC = NH + 3;
    localparam logic [63:0] MAXV = (64'd1 << W) - 64'd1;

    logic          clk;
    logic          rst;
    logic          csr_access;
    logic [11:0]   csr_addr;
    logic [1:0]    csr_op;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_hit;
    logic          instr_ret;
    logic [NE-1:0] event_v;
    logic          count_stop;
    logic          ovf_irq_en;
    logic [NC-1:0] ovf;
    logic          ovf_irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rdata;

    // Reference model state
    logic [63:0]   mcnt [NC];
    logic [31:0]   mevt [NC];
    logic [31:0]   minh;
    logic [NC-1:0] movf;

    ibex_perf_counter_bank #(
        .NUM_HPM      (NH),
        .COUNTER_WIDTH(W),
        .NUM_EVENTS   (NE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .csr_access_i(csr_access),
        .csr_addr_i  (csr_addr),
        .csr_op_i    (csr_op),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .csr_hit_o   (csr_hit),
        .instr_ret_i (instr_ret),
        .event_i     (event_v),
        .count_stop_i(count_stop),
        .ovf_irq_en_i(ovf_irq_en),
        .ovf_o       (ovf),
        .ovf_irq_o   (ovf_irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mcnt[k] = 64'd0;
            mevt[k] = 32'd0;
        end
        minh = 32'd0;
        movf = '0;
    endtask

    function automatic logic m_hit(input logic [11:0] a);
        return (a >= 12'h320 && a <= 12'h33F) || (a >= 12'hB00 && a <= 12'hB1F) ||
               (a >= 12'hB80 && a <= 12'hB9F);
    endfunction

    // Counter number addressed by a, or -1 when a names no implemented counter.
    function automatic int cnt_index(input logic [11:0] a);
        int k;
        k = -1;
        if (a >= 12'hB00 && a <= 12'hB1F) k = int'(a) - 'hB00;
        if (a >= 12'hB80 && a <= 12'hB9F) k = int'(a) - 'hB80;
        if (k >= NC || k == 1) k = -1;
        return k;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int k;
        if (a == 12'h320) return minh;
        if (int'(a) >= 'h323 && int'(a) < 'h323 + NH) return mevt[int'(a) - 'h320];
        k = cnt_index(a);
        if (k < 0) return 32'd0;
        return (a < 12'hB80) ? mcnt[k][31:0] : mcnt[k][63:32];
    endfunction

    task automatic model_update();
        logic [31:0] oldv;
        logic [31:0] nv;
        logic        wr;
        logic        inc;
        int          kw;
        oldv = m_read(csr_addr);
        case (csr_op)
            2'd1:    nv = csr_wdata;
            2'd2:    nv = oldv | csr_wdata;
            2'd3:    nv = oldv & ~csr_wdata;
            default: nv = oldv;
        endcase
        wr = csr_access && (csr_op != 2'd0);
        kw = wr ? cnt_index(csr_addr) : -1;
        for (int k = 0; k < NC; k++) begin
            inc = !minh[k] && !count_stop &&
                  (k == 0 || (k == 2 && instr_ret) || (k >= 3 && (event_v & mevt[k][NE-1:0]) != 0));
            if (k == kw) begin
                if (csr_addr < 12'hB80) mcnt[k] = {mcnt[k][63:32], nv};
                else                    mcnt[k] = {nv, mcnt[k][31:0]} & MAXV;
                movf[k] = 1'b0;
            end else if (inc) begin
                if (mcnt[k] == MAXV) begin
                    mcnt[k] = 64'd0;
                    movf[k] = 1'b1;
                end else begin
                    mcnt[k] = mcnt[k] + 64'd1;
                end
            end
        end
        if (wr && csr_addr == 12'h320) minh = nv & ((32'd1 << NC) - 32'd1) & ~32'd2;
        if (wr && int'(csr_addr) >= 'h323 && int'(csr_addr) < 'h323 + NH)
            mevt[int'(csr_addr) - 'h320] = nv & ((32'd1 << NE) - 32'd1);
    endtask

    // Driver: apply one cycle of inputs at the falling edge, check the combinational
    // read path, advance the model and the DUT by one rising edge, check flags.
    task automatic step(input logic acc, input logic [11:0] addr, input logic [1:0] op,
                        input logic [31:0] wd, input logic ret, input logic [NE-1:0] ev,
                        input logic stop);
        csr_access = acc;
        csr_addr   = addr;
        csr_op     = op;
        csr_wdata  = wd;
        instr_ret  = ret;
        event_v    = ev;
        count_stop = stop;
        #1;
        last_rdata = csr_rdata;
        check("hit", csr_hit, m_hit(addr));
        check("rdata", csr_rdata, acc ? m_read(addr) : 32'd0);
        model_update();
        @(posedge clk);
        @(negedge clk);
        check("ovf", ovf, movf);
        check("irq", ovf_irq, ovf_irq_en && (|movf));
    endtask

    task automatic rd(input logic [11:0] addr);
        step(1'b1, addr, 2'd0, 32'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
        step(1'b1, addr, op, wd, 1'b0, '0, 1'b0);
    endtask

    logic [63:0] snap0;
    logic [63:0] snap2;
    logic [63:0] snap3;
    logic [11:0] addrs [$];
    logic [31:0] wd;

    initial begin
        rst = 1'b1;
        csr_access = 1'b1;
        csr_addr = 12'hB00;
        csr_op = 2'd0;
        csr_wdata = 32'd0;
        instr_ret = 1'b0;
        event_v = '0;
        count_stop = 1'b0;
        ovf_irq_en = 1'b1;
        model_reset();
        #1;
        check("reset_rdata", csr_rdata, 32'd0);
        check("reset_ovf", ovf, '0);
        check("reset_irq", ovf_irq, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ovf_irq_en = 1'b0;

        // Free-running mcycle
        repeat (10) step(1'b0, 12'h000, 2'd0, 32'd0, 1'b0, '0, 1'b0);
        rd(12'hB00);
        check("mcycle_10", last_rdata, 32'd10);
        rd(12'hB80);
        check("mcycle_hi_0", last_rdata, 32'd0);

        // Event selection
        wr(12'h323, 2'd1, 32'h5);
        repeat (3) step(1'b0, 12'h000, 2'd0, 32'd0, 1'b0, NE'(4), 1'b0);
        repeat (2) step(1'b0, 12'h000, 2'd0, 32'd0, 1'b0, NE'(2), 1'b0);
        rd(12'hB03);
        check("hpm3_count", last_rdata, 32'd3);

        // mcycle wrap, overflow flag and interrupt
        wr(12'hB80, 2'd1, 32'hFF);
        wr(12'hB00, 2'd1, 32'hFFFF_FFFF);
        ovf_irq_en = 1'b1;
        rd(12'hB00);
        check("mcycle_allones", last_rdata, 32'hFFFF_FFFF);
        check("wrap_ovf0", ovf[0], 1'b1);
        check("wrap_irq", ovf_irq, 1'b1);
        rd(12'hB00);
        check("mcycle_wrapped", last_rdata, 32'd0);
        ovf_irq_en = 1'b0;
        #1;
        check("irq_disabled", ovf_irq, 1'b0);
        wr(12'hB00, 2'd1, 32'd0);
        check("ovf0_cleared", ovf[0], 1'b0);

        // Write beats a same-cycle retire
        step(1'b1, 12'hB02, 2'd1, 32'd100, 1'b1, '0, 1'b0);
        rd(12'hB02);
        check("minstret_write_wins", last_rdata, 32'd100);
        step(1'b0, 12'h000, 2'd0, 32'd0, 1'b1, '0, 1'b0);
        rd(12'hB02);
        check("minstret_next_retire", last_rdata, 32'd101);

        // mcountinhibit
        wr(12'h320, 2'd1, 32'h5);
        snap0 = mcnt[0];
        snap2 = mcnt[2];
        repeat (20) step(1'b0, 12'h000, 2'd0, 32'd0, 1'b1, '0, 1'b0);
        rd(12'h320);
        check("inhibit_read", last_rdata, 32'h5);
        rd(12'hB00);
        check("inhibit_cycle", last_rdata, snap0[31:0]);
        rd(12'hB02);
        check("inhibit_instret", last_rdata, snap2[31:0]);
        wr(12'h320, 2'd3, 32'h5);
        rd(12'hB00);
        check("uninhibit_same_cycle", last_rdata, snap0[31:0]);
        rd(12'hB00);
        check("uninhibit_next_cycle", last_rdata, snap0[31:0] + 32'd1);

        // Debug stopcount
        snap0 = mcnt[0];
        snap2 = mcnt[2];
        snap3 = mcnt[3];
        step(1'b1, 12'hB1F, 2'd0, 32'd0, 1'b1, NE'(4), 1'b1);
        check("unimpl_rdata", last_rdata, 32'd0);
        check("unimpl_hit", csr_hit, 1'b1);
        step(1'b1, 12'h7B0, 2'd0, 32'd0, 1'b1, NE'(4), 1'b1);
        check("foreign_hit", csr_hit, 1'b0);
        repeat (5) begin
            step(1'b1, 12'hB00, 2'd0, 32'd0, 1'b1, NE'(4), 1'b1);
            check("stop_cycle", last_rdata, snap0[31:0]);
        end
        rd(12'hB02);
        check("stop_instret", last_rdata, snap2[31:0]);
        rd(12'hB03);
        check("stop_hpm3", last_rdata, snap3[31:0]);

        // Randomized traffic
        addrs = {12'h320, 12'h321, 12'h322, 12'h323, 12'h324, 12'h32A, 12'h32B, 12'h33F,
                 12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB05, 12'hB0A, 12'hB0B, 12'hB1F,
                 12'hB80, 12'hB81, 12'hB82, 12'hB83, 12'hB8A, 12'hB8B, 12'hB9F, 12'h7B0,
                 12'hC00, 12'h300};
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 7))
                0:       wd = 32'd0;
                1:       wd = 32'hFFFF_FFFF;
                2:       wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                3:       wd = 32'hFF;
                4:       wd = 32'($urandom_range(0, 7));
                default: wd = $urandom;
            endcase
            ovf_irq_en = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, addrs[$urandom_range(0, addrs.size() - 1)],
                 2'($urandom_range(0, 3)), wd, 1'($urandom_range(0, 1)),
                 NE'($urandom) & NE'($urandom) & NE'($urandom), $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in mid-operation
        wr(12'h320, 2'd1, 32'd0);
        wr(12'hB82, 2'd1, 32'hFF);
        wr(12'hB02, 2'd1, 32'hFFFF_FFFF);
        step(1'b0, 12'h000, 2'd0, 32'd0, 1'b1, '0, 1'b0);
        check("pre_reset_ovf2", ovf[2], 1'b1);
        ovf_irq_en = 1'b1;
        #2;
        rst = 1'b1;
        csr_access = 1'b1;
        csr_addr = 12'hB02;
        csr_op = 2'd0;
        #1;
        check("async_reset_rdata", csr_rdata, 32'd0);
        check("async_reset_ovf", ovf, '0);
        check("async_reset_irq", ovf_irq, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd(12'hB00);
        check("post_reset_cycle0", last_rdata, 32'd0);
        rd(12'hB00);
        check("post_reset_cycle1", last_rdata, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
